uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer directly downstream of uart_receiver. Captures each completed
//  frame (rx_data plus its rx_err flag) on the rising edge of rx_finished and queues it in
//  a DEPTH-entry first-word-fall-through FIFO. The host drains the FIFO with rd_en.
//  Overrun is reported through a sticky overflow flag.
// PARAMETERS
//  DEPTH      16  entries; must be a power of 2, minimum 2
//  AW         4   log2(DEPTH); pointer index width
//  AFULL_LVL  12  almost_full asserts when level >= AFULL_LVL (1..DEPTH)
// PORTS
//  clk          in   1     system clock; all state updates on the rising edge
//  rst_n        in   1     asynchronous reset, active-low
//  rx_data      in   8     received byte from uart_receiver.data
//  rx_finished  in   1     frame-complete level/pulse from uart_receiver.finished
//  rx_err       in   1     frame error flag from uart_receiver.err; valid with rx_finished
//  rd_en        in   1     pop request from host
//  rd_data      out  8     head-of-queue byte (FWFT); 8'h00 when empty
//  rd_err       out  1     error tag of the head entry; 0 when empty
//  empty        out  1     level == 0
//  full         out  1     level == DEPTH
//  almost_full  out  1     level >= AFULL_LVL
//  level        out  AW+1  number of stored entries, 0..DEPTH
//  overflow     out  1     sticky: a frame was dropped because the FIFO was full
//  clr_ovf      in   1     synchronous clear of overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, fin_q=0, overflow=0 -> level=0, empty=1,
//    full=0, almost_full=0, rd_data=8'h00, rd_err=0. Memory contents are not reset.
//  - Edge detect: fin_q <= rx_finished each cycle; wr_evt = rx_finished & ~fin_q.
//    A held-high rx_finished produces exactly one write. rx_finished already high on the
//    first edge after reset produces one write.
//  - Storage: 9-bit entries {rx_err, rx_data}. Pointers are AW+1 bits and wrap mod 2*DEPTH.
//    level = wr_ptr - rd_ptr; full when the MSBs differ and the low AW bits are equal.
//  - Write: on an edge with wr_evt=1 and (!full or pop accepted the same edge), store the
//    entry at wr_ptr[AW-1:0] and increment wr_ptr. Write latency: entry visible on
//    rd_data and empty=0 right after the capturing edge.
//  - Drop: wr_evt=1, full=1 and no accepted pop -> entry discarded, pointers unchanged,
//    overflow <= 1.
//  - Read: pop accepted when rd_en=1 and empty=0; rd_ptr increments at that edge and the
//    next entry falls through combinationally. rd_en while empty is ignored.
//  - Simultaneous push+pop: full -> both accepted, level unchanged, no overflow;
//    empty -> push only, level becomes 1; otherwise level unchanged.
//  - overflow: set has priority over clr_ovf in the same cycle; otherwise clr_ovf=1 clears.
//  - rd_data/rd_err are gated to 0 when empty. All flags derive combinationally from the
//    registered pointers (glitch-free relative to clk).
//  - Reset mid-operation: queued data is discarded immediately. A frame completing during
//    reset is lost; a rx_finished still high at reset release is captured once (see above).
// TESTING
//  1 Reset: rst_n low mid-run -> level=0, empty=1, rd_data=8'h00, overflow=0 immediately.
//  2 Single frame: rx_data=8'hC1, rx_err=0, rx_finished high for 5 cycles -> level=1,
//    rd_data=8'hC1, rd_err=0 next cycle; one rd_en -> empty=1.
//  3 Error tag: rx_data=8'h41 with rx_err=1 -> rd_data=8'h41 and rd_err=1 at the head.
//  4 Fill/overrun: 16 frames 8'h00..8'h0F -> full=1, almost_full asserted from the 12th
//    frame. 17th frame 8'hFF -> dropped, overflow=1. Drain returns 8'h00..8'h0F in order.
//  5 Full push+pop: at full, pulse rx_finished with rd_en=1 -> level stays 16, overflow
//    stays 0, new byte emerges last. clr_ovf with a coincident drop -> overflow stays 1.
//  6 Wrap: 40 interleaved push/pop cycles crossing the pointer wrap -> data order is
//    preserved; rd_en on empty leaves level=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT receive FIFO capturing uart_receiver frames with sticky overflow
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_finished,
  input  logic          rx_err,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clr_ovf
);

  logic [8:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fin_q, fin_d;
  logic        ovf_q, ovf_d;
  logic        wr_evt, pop, push, drop;
  logic [8:0]  head;

  always_comb begin
    level       = wr_ptr_q - rd_ptr_q;
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    almost_full = (level >= (AW+1)'(AFULL_LVL));
    overflow    = ovf_q;
    head        = mem[rd_ptr_q[AW-1:0]];
    rd_data     = empty ? 8'h00 : head[7:0];
    rd_err      = empty ? 1'b0  : head[8];
  end

  // A pop on the same edge frees the slot, so a write into a full FIFO is still accepted.
  always_comb begin
    wr_evt   = rx_finished & ~fin_q;
    pop      = rd_en & ~empty;
    push     = wr_evt & (~full | pop);
    drop     = wr_evt & full & ~pop;
    fin_d    = rx_finished;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fin_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fin_q    <= fin_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {rx_err, rx_data};
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_finished;
  logic       rx_err;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .AFULL_LVL(12)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_finished(rx_finished),
    .rx_err(rx_err), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .almost_full(almost_full), .level(level),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e);
    rx_data = d; rx_err = e; rx_finished = 1'b1;
    tick();
    rx_finished = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_data = 8'h00; rx_finished = 1'b0; rx_err = 1'b0;
    rd_en = 1'b0; clr_ovf = 1'b0;
    #2;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        rd_data !== 8'h00 || rd_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%0d empty=%b full=%b af=%b rd_data=%h rd_err=%b ovf=%b, want 0 1 0 0 00 0 0",
               level, empty, full, almost_full, rd_data, rd_err, overflow);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b0);
    checks++;
    if (level !== 5'd3) begin
      errors++; $display("FAIL pre_reset_level: got %0d want 3", level);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: level=%0d empty=%b rd_data=%h ovf=%b, want 0 1 00 0",
               level, empty, rd_data, overflow);
    end
    rx_data = 8'h5A; rx_finished = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (level !== 5'd1 || rd_data !== 8'h5A) begin
      errors++;
      $display("FAIL finished_at_release: level=%0d rd_data=%h, want 1 5a", level, rd_data);
    end
    rx_finished = 1'b0;
    pop_one();
    tick();
  endtask

  task automatic test_single();
    rx_data = 8'hC1; rx_err = 1'b0; rx_finished = 1'b1;
    tick();
    checks++;
    if (level !== 5'd1 || rd_data !== 8'hC1 || rd_err !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: level=%0d rd_data=%h rd_err=%b empty=%b, want 1 c1 0 0",
               level, rd_data, rd_err, empty);
    end
    repeat (4) tick();
    checks++;
    if (level !== 5'd1) begin
      errors++; $display("FAIL single_held_high: level=%0d want 1", level);
    end
    rx_finished = 1'b0;
    tick();
    pop_one();
    checks++;
    if (empty !== 1'b1 || rd_data !== 8'h00) begin
      errors++; $display("FAIL single_pop: empty=%b rd_data=%h, want 1 00", empty, rd_data);
    end
  endtask

  task automatic test_err_tag();
    send_frame(8'h41, 1'b1);
    checks++;
    if (rd_data !== 8'h41 || rd_err !== 1'b1) begin
      errors++; $display("FAIL err_tag: rd_data=%h rd_err=%b, want 41 1", rd_data, rd_err);
    end
    pop_one();
    checks++;
    if (rd_err !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL err_tag_gate: rd_err=%b empty=%b, want 0 1", rd_err, empty);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) begin
      send_frame(8'(i), 1'b0);
      checks++;
      if (almost_full !== (i + 1 >= 12) || level !== 5'(i + 1)) begin
        errors++;
        $display("FAIL fill_af[%0d]: af=%b level=%0d, want %b %0d", i, almost_full, level,
                 (i + 1 >= 12), i + 1);
      end
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL fill_full: full=%b ovf=%b, want 1 0", full, overflow);
    end
    send_frame(8'hFF, 1'b0);
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++; $display("FAIL overrun: ovf=%b level=%0d, want 1 16", overflow, level);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== 8'(i)) begin
        errors++; $display("FAIL drain[%0d]: got %h want %h", i, rd_data, 8'(i));
      end
      pop_one();
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL drain_empty: empty=%b full=%b, want 1 0", empty, full);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_ovf: got %b want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) send_frame(8'h10 + 8'(i), 1'b0);
    rx_data = 8'hA5; rx_finished = 1'b1; rd_en = 1'b1;
    tick();
    rx_finished = 1'b0; rd_en = 1'b0;
    checks++;
    if (level !== 5'd16 || overflow !== 1'b0 || rd_data !== 8'h11) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d ovf=%b head=%h, want 16 0 11", level, overflow, rd_data);
    end
    tick();
    send_frame(8'h66, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL full_drop: ovf=%b want 1", overflow);
    end
    rx_data = 8'h77; rx_finished = 1'b1; clr_ovf = 1'b1;
    tick();
    rx_finished = 1'b0; clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++; $display("FAIL set_over_clr: ovf=%b level=%0d, want 1 16", overflow, level);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== ((i < 15) ? 8'h11 + 8'(i) : 8'hA5)) begin
        errors++;
        $display("FAIL full_drain[%0d]: got %h want %h", i, rd_data,
                 (i < 15) ? 8'h11 + 8'(i) : 8'hA5);
      end
      pop_one();
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_drain_end: empty=%b ovf=%b, want 1 0", empty, overflow);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic       prev_fin = 1'b0;
    logic [7:0] exp_head;
    for (int i = 0; i < 40; i++) begin
      rx_data     = 8'(i * 7 + 3);
      rx_err      = 1'b0;
      rx_finished = (i % 2 == 0);
      rd_en       = (i % 3 != 0);
      if (q.size() > 0) begin
        exp_head = q[0];
        checks++;
        if (rd_data !== exp_head) begin
          errors++; $display("FAIL wrap_head[%0d]: got %h want %h", i, rd_data, exp_head);
        end
      end
      if (rd_en && q.size() > 0) void'(q.pop_front());
      if (rx_finished && !prev_fin) q.push_back(rx_data);
      prev_fin = rx_finished;
      tick();
      checks++;
      if (level !== 5'(q.size())) begin
        errors++; $display("FAIL wrap_level[%0d]: got %0d want %0d", i, level, q.size());
      end
    end
    rx_finished = 1'b0; rd_en = 1'b0;
    tick();
    while (q.size() > 0) begin
      exp_head = q.pop_front();
      checks++;
      if (rd_data !== exp_head) begin
        errors++; $display("FAIL wrap_drain: got %h want %h", rd_data, exp_head);
      end
      pop_one();
    end
    pop_one();
    pop_one();
    checks++;
    if (level !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL rd_on_empty: level=%0d empty=%b, want 0 1", level, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_err_tag();
    test_fill_overrun();
    test_full_push_pop();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
